// File: rtl/updown_seq_checker_pkg.sv
// updown_pkg: state codes and prediction helpers shared by the up/down sequence checker
package updown_pkg;
    typedef logic [1:0] state_t;
    localparam state_t EMPTY = 2'd0;
    localparam state_t ONE   = 2'd1;
    localparam state_t LOCK  = 2'd2;
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction
    // Ping-pong prediction: the ends turn around instead of wrapping
    function automatic int next_exp(input int prev, input logic dir_up, input int max);
        return dir_up ? ((prev < max) ? prev + 1 : max - 1) : ((prev > 0) ? prev - 1 : 1);
    endfunction
endpackage

// File: rtl/updown_seq_checker_if.sv
// updown_seq_checker_if: sample stream into the checker and its status outputs
interface updown_seq_checker_if #(parameter int WIDTH = 3, parameter int ERR_W = 8);
    logic             in_valid;
    logic [WIDTH-1:0] count_in;
    logic             locked;
    logic             dir_up;
    logic             err;
    logic             peak;
    logic             trough;
    logic [ERR_W-1:0] err_cnt;
    modport master (output in_valid, count_in, input locked, dir_up, err, peak, trough, err_cnt);
    modport slave (input in_valid, count_in, output locked, dir_up, err, peak, trough, err_cnt);
endinterface

// File: rtl/updown_seq_checker_sat_counter.sv
// sat_counter: counter that sticks at all-ones, cleared synchronously
module sat_counter #(parameter int ERR_W = 8) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [ERR_W-1:0] q
);
    // Count increments until every bit is set, then hold
    always_ff @(posedge clk)
        q <= clr ? '0 : (inc && !(&q)) ? q + ERR_W'(1) : q;
endmodule

// File: rtl/updown_seq_checker.sv
// updown_seq_checker: locks onto a ping-pong counter stream and flags deviations; CHK_STALL_EN treats repeats as stalls
module updown_seq_checker
    import updown_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int ERR_W = 8
) (
    input logic clk,
    input logic rst,
    updown_seq_checker_if.slave bus
);
    localparam int MAX = cnt_max(WIDTH);
    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [WIDTH-1:0] INC = 1;
    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] exp_v;
    logic             stall;
    logic             hit;
    logic             go_up;
    logic             go_dn;
    logic             mis;
    assign s     = bus.count_in;
    assign exp_v = WIDTH'(next_exp(int'(prev), bus.dir_up, MAX));
    assign hit   = s == exp_v;
    assign go_up = prev != MAXV && s == prev + INC;
    assign go_dn = prev != '0 && s == prev - INC;
`ifdef CHK_STALL_EN
    assign stall = state != EMPTY && s == prev;
`else
    assign stall = 1'b0;
`endif
    assign mis = bus.in_valid && state == LOCK && !stall && !hit;
    sat_counter #(.ERR_W(ERR_W)) u_cnt (
        .clk(clk),
        .clr(rst),
        .inc(mis),
        .q  (bus.err_cnt)
    );
    // Acquire phase/direction, then track predictions and raise the 1-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            prev       <= '0;
            bus.locked <= 1'b0;
            bus.dir_up <= 1'b1;
            bus.err    <= 1'b0;
            bus.peak   <= 1'b0;
            bus.trough <= 1'b0;
        end else begin
            bus.err    <= mis;
            bus.peak   <= 1'b0;
            bus.trough <= 1'b0;
            if (bus.in_valid && !stall) begin
                prev <= s;
                case (state)
                    EMPTY: state <= ONE;
                    ONE: begin
                        if (go_up || go_dn) begin
                            state      <= LOCK;
                            bus.locked <= 1'b1;
                            bus.dir_up <= go_up;
                        end
                    end
                    LOCK: begin
                        if (hit) begin
                            bus.dir_up <= exp_v > prev;
                            bus.peak   <= s == MAXV;
                            bus.trough <= s == '0;
                        end else begin
                            state      <= ONE;
                            bus.locked <= 1'b0;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_updown_seq_checker.sv
// tb_updown_seq_checker: directed scoreboard bench for updown_seq_checker
module tb_updown_seq_checker;
    typedef struct packed {
        logic       locked;
        logic       dir_up;
        logic       err;
        logic       peak;
        logic       trough;
        logic [7:0] cnt;
    } exp_t;
`ifdef CHK_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    updown_seq_checker_if #(.WIDTH(3), .ERR_W(8)) bus ();
    updown_seq_checker #(.WIDTH(3), .ERR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   nstep = 0;
    int   m_st, m_prev, m_cnt;
    bit   m_lock, m_dir;

    task automatic chk(input string tag, input logic [7:0] a, input logic [7:0] e);
        total++;
        assert (a === e) else begin
            bad++;
            $error("FAIL %s step=%0d got=%0h exp=%0h", tag, nstep, a, e);
        end
    endtask

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        chk("locked", {7'd0, bus.locked}, {7'd0, e.locked});
        chk("dir_up", {7'd0, bus.dir_up}, {7'd0, e.dir_up});
        chk("err", {7'd0, bus.err}, {7'd0, e.err});
        chk("peak", {7'd0, bus.peak}, {7'd0, e.peak});
        chk("trough", {7'd0, bus.trough}, {7'd0, e.trough});
        chk("err_cnt", bus.err_cnt, e.cnt);
    endtask

    task automatic do_rst();
        exp_t e;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        m_st = 0; m_prev = 0; m_cnt = 0; m_lock = 1'b0; m_dir = 1'b1;
        e = '0;
        e.dir_up = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nstep++;
        check();
    endtask

    task automatic step(input bit v, input int s);
        exp_t e;
        int   ex;
        e = '0;
        bus.in_valid = v;
        bus.count_in = 3'(s);
        if (v) begin
            if (m_st == 0) begin
                m_prev = s;
                m_st = 1;
            end else if (STALL && s == m_prev) begin
            end else if (m_st == 1) begin
                if (m_prev < 7 && s == m_prev + 1) begin
                    m_st = 2; m_lock = 1'b1; m_dir = 1'b1;
                end else if (m_prev > 0 && s == m_prev - 1) begin
                    m_st = 2; m_lock = 1'b1; m_dir = 1'b0;
                end
                m_prev = s;
            end else begin
                if (m_dir) ex = (m_prev == 7) ? 6 : m_prev + 1;
                else ex = (m_prev == 0) ? 1 : m_prev - 1;
                if (s == ex) begin
                    if (m_prev == 7) m_dir = 1'b0;
                    if (m_prev == 0) m_dir = 1'b1;
                    e.peak = (s == 7);
                    e.trough = (s == 0);
                end else begin
                    e.err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    m_lock = 1'b0;
                    m_st = 1;
                end
                m_prev = s;
            end
        end
        e.locked = m_lock;
        e.dir_up = m_dir;
        e.cnt = 8'(m_cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        nstep++;
        check();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.count_in = '0;
        do_rst();
        for (int i = 0; i <= 7; i++) step(1, i);
        for (int i = 6; i >= 0; i--) step(1, i);
        step(1, 1);
        for (int i = 2; i <= 5; i++) step(1, i);
        step(1, 3);
        step(1, 4);
        step(1, 5); step(1, 6); step(1, 7);
        step(1, 0);
        step(1, 7); step(1, 6);
        for (int i = 5; i >= 0; i--) step(1, i);
        for (int i = 1; i <= 4; i++) step(1, i);
        repeat (10) step(0, $urandom_range(0, 7));
        step(1, 5);
        step(1, 6); step(1, 7); step(1, 6); step(1, 5); step(1, 4); step(1, 3);
        step(1, 3);
        step(1, 2);
        repeat (300) begin
            step(1, 3);
            step(1, 4);
            step(1, 0);
        end
        step(1, 3);
        step(1, 4);
        do_rst();
        step(1, 2);
        step(1, 3);
        step(1, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
